mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, variable-latency unified memory between the core's
//  instruction-fetch port (I) and data port (D). Sits between the pipelined ARM
//  core (PCF/InstrF, ALUResultM/WriteDataM/ReadDataM/MemWriteM) and the memory.
//  Runs a grant FSM with data-priority arbitration, an anti-starvation counter
//  and a per-access timeout. Returns Ready/Err pulses that the core's hazard
//  logic uses to stall.
// PARAMETERS
//  AW         32   address width
//  DW         32   data width
//  STARVE_MAX 4    consecutive D grants allowed while IReq waits; then I wins once
//  TIMEOUT    255  MemReq cycles without MemAck before abort; 0 = timeout disabled
// PORTS
//  clk       in   1   single clock, rising edge
//  reset     in   1   asynchronous, active-low; clears all state
//  IReq      in   1   fetch request (level)
//  IAddr     in   AW  fetch address
//  IRdata    out  DW  fetch data, valid while IReady=1
//  IReady    out  1   1-cycle pulse: fetch completed
//  IErr      out  1   1-cycle pulse with IReady: fetch timed out
//  DReq      in   1   data request (level)
//  DWe       in   1   1=write, 0=read
//  DAddr     in   AW  data address
//  DWdata    in   DW  write data
//  DRdata    out  DW  read data, valid while DReady=1 (0 for writes)
//  DReady    out  1   1-cycle pulse: data access completed
//  DErr      out  1   1-cycle pulse with DReady: data access timed out
//  MemReq    out  1   memory request, held until MemAck or timeout
//  MemWe     out  1   memory write enable, valid with MemReq
//  MemAddr   out  AW  memory address, stable while MemReq=1
//  MemWdata  out  DW  memory write data, stable while MemReq=1
//  MemRdata  in   DW  memory read data, sampled when MemAck=1
//  MemAck    in   1   memory completion, sampled only while MemReq=1
// BEHAVIOUR
//  Reset:
//   - Every output is 0.
//   - FSM=IDLE; starve_cnt=0; timeout counter=0.
//   - Reset mid-access drops MemReq immediately; no Ready pulse follows.
//  FSM states: IDLE, BUSY_I, BUSY_D. All outputs are registered.
//  IDLE arbitration (at a clock edge):
//   - DReq & IReq & starve_cnt==STARVE_MAX -> grant I.
//   - Otherwise DReq -> grant D.
//   - Otherwise IReq -> grant I.
//   - The winner's Addr/We/Wdata are latched into Mem*, MemReq=1, and the FSM
//     moves to BUSY_x. I grants force MemWe=0.
//   - The requester needs stable fields only at the grant edge.
//  starve_cnt:
//   - +1 (saturating at STARVE_MAX) on a D grant while IReq=1.
//   - Cleared on an I grant, or at any arbitration edge where IReq=0.
//  BUSY_x, on the edge where MemAck=1:
//   - MemReq=0.
//   - xRdata <= MemRdata (DRdata <= 0 for writes).
//   - xReady=1 for exactly one cycle, then back to IDLE.
//   - Minimum latency is 2 edges from request to Ready. There is one IDLE
//     turnaround cycle between accesses.
//  Timeout (TIMEOUT>0):
//   - The counter increments each BUSY cycle with MemAck=0.
//   - When it reaches TIMEOUT: MemReq=0, xReady=1, xErr=1, xRdata=0, -> IDLE.
//   - MemAck on the same edge as expiry wins: normal completion, Err=0.
//  Deasserting Req while BUSY does not abort; Ready still pulses.
//  A Req held high after Ready is treated as a new request at the next IDLE edge.
//  IReady and DReady are never both 1. Only one transaction is outstanding.
// TESTING
//  1. Single I read, MemAck immediate, MemRdata=0xE3A00001
//     -> IReady=1 two edges after IReq, IRdata=0xE3A00001, MemWe=0.
//  2. IReq and DReq together, D write 0x100<-0xDEADBEEF
//     -> D granted first (MemWe=1, MemAddr=0x100); I served next; no overlap.
//  3. DReq held continuously with IReq high
//     -> 4 D grants, then 1 I grant, then the pattern repeats.
//  4. TIMEOUT=8, MemAck never asserted on a D read
//     -> MemReq low after 8 cycles; DReady=DErr=1; DRdata=0.
//  5. MemAck on the expiry edge -> normal completion, DErr=0.
//  6. reset low mid-BUSY_D
//     -> all outputs 0 immediately; no DReady; next I request served normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles every signal between the arbiter, the core and the unified memory.
//   clk and reset stay outside as plain module ports.
//   Core fetch side : IReq, IAddr -> arbiter ; IRdata, IReady, IErr <- arbiter
//   Core data side  : DReq, DWe, DAddr, DWdata -> arbiter ;
//                     DRdata, DReady, DErr <- arbiter
//   Memory side     : MemReq, MemWe, MemAddr, MemWdata <- arbiter ;
//                     MemRdata, MemAck -> arbiter
//   Modports: slave  = the arbiter's view
//             master = the surrounding core/memory view
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          IReq;
  logic [AW-1:0] IAddr;
  logic [DW-1:0] IRdata;
  logic          IReady;
  logic          IErr;
  logic          DReq;
  logic          DWe;
  logic [AW-1:0] DAddr;
  logic [DW-1:0] DWdata;
  logic [DW-1:0] DRdata;
  logic          DReady;
  logic          DErr;
  logic          MemReq;
  logic          MemWe;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWdata;
  logic [DW-1:0] MemRdata;
  logic          MemAck;

  modport slave (
    input  IReq, IAddr, DReq, DWe, DAddr, DWdata, MemRdata, MemAck,
    output IRdata, IReady, IErr, DRdata, DReady, DErr,
           MemReq, MemWe, MemAddr, MemWdata
  );

  modport master (
    output IReq, IAddr, DReq, DWe, DAddr, DWdata, MemRdata, MemAck,
    input  IRdata, IReady, IErr, DRdata, DReady, DErr,
           MemReq, MemWe, MemAddr, MemWdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, variable-latency memory between the core's
//   instruction-fetch port (I) and data port (D). Data wins arbitration unless
//   the fetch port has been passed over STARVE_MAX times in a row; each access
//   is aborted with an error pulse after TIMEOUT cycles without MemAck
//   (TIMEOUT = 0 disables the abort). All outputs are registered.
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low; clears every output and all state
//   bus    : mem_port_arbiter_if.slave carrying the I, D and Mem* signals
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_port_arbiter_if.slave      bus
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tcnt;
  logic          expire;
  logic          starve_hit;

  // The counter reaching TIMEOUT on this edge means it currently holds
  // TIMEOUT-1 and MemAck is still low.
  always_comb begin
    expire     = 1'b0;
    starve_hit = (starve_cnt == SW'(STARVE_MAX));
    if (TIMEOUT != 0)
      expire = (tcnt == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      tcnt         <= '0;
      bus.IRdata   <= '0;
      bus.IReady   <= 1'b0;
      bus.IErr     <= 1'b0;
      bus.DRdata   <= '0;
      bus.DReady   <= 1'b0;
      bus.DErr     <= 1'b0;
      bus.MemReq   <= 1'b0;
      bus.MemWe    <= 1'b0;
      bus.MemAddr  <= '0;
      bus.MemWdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Ready/Err are one-cycle pulses; this idle cycle is the turnaround.
          bus.IReady <= 1'b0;
          bus.IErr   <= 1'b0;
          bus.DReady <= 1'b0;
          bus.DErr   <= 1'b0;
          tcnt       <= '0;
          if (bus.DReq && bus.IReq && starve_hit) begin
            state        <= BUSY_I;
            starve_cnt   <= '0;
            bus.MemReq   <= 1'b1;
            bus.MemWe    <= 1'b0;
            bus.MemAddr  <= bus.IAddr;
            bus.MemWdata <= '0;
          end else if (bus.DReq) begin
            state        <= BUSY_D;
            bus.MemReq   <= 1'b1;
            bus.MemWe    <= bus.DWe;
            bus.MemAddr  <= bus.DAddr;
            bus.MemWdata <= bus.DWdata;
            // Only count D grants that actually made a waiting fetch wait.
            if (!bus.IReq)
              starve_cnt <= '0;
            else if (!starve_hit)
              starve_cnt <= starve_cnt + 1'b1;
          end else if (bus.IReq) begin
            state        <= BUSY_I;
            starve_cnt   <= '0;
            bus.MemReq   <= 1'b1;
            bus.MemWe    <= 1'b0;
            bus.MemAddr  <= bus.IAddr;
            bus.MemWdata <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end

        BUSY_I, BUSY_D: begin
          // MemAck beats a simultaneous expiry: completion is normal.
          if (bus.MemAck) begin
            state      <= IDLE;
            bus.MemReq <= 1'b0;
            if (state == BUSY_I) begin
              bus.IRdata <= bus.MemRdata;
              bus.IReady <= 1'b1;
            end else begin
              bus.DRdata <= bus.MemWe ? '0 : bus.MemRdata;
              bus.DReady <= 1'b1;
            end
          end else if (expire) begin
            state      <= IDLE;
            bus.MemReq <= 1'b0;
            if (state == BUSY_I) begin
              bus.IRdata <= '0;
              bus.IReady <= 1'b1;
              bus.IErr   <= 1'b1;
            end else begin
              bus.DRdata <= '0;
              bus.DReady <= 1'b1;
              bus.DErr   <= 1'b1;
            end
          end else if (TIMEOUT != 0) begin
            tcnt <= tcnt + 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          bus.MemReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (STARVE_MAX=4, TIMEOUT=8). Inputs are
//   driven and outputs sampled on the falling clock edge.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_MAX(4), .TIMEOUT(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] flags();
    return {22'd0, bus.IReady, bus.IErr, bus.DReady, bus.DErr, bus.MemReq,
            bus.MemWe, 4'd0};
  endfunction

  initial begin
    bus.IReq = 0; bus.IAddr = 0; bus.DReq = 0; bus.DWe = 0; bus.DAddr = 0;
    bus.DWdata = 0; bus.MemRdata = 0; bus.MemAck = 0;

    // Reset state
    step();
    check("rst_flags", flags(), 32'h0);
    check("rst_addr", bus.MemAddr, 32'h0);
    check("rst_wdata", bus.MemWdata, 32'h0);
    check("rst_irdata", bus.IRdata, 32'h0);
    check("rst_drdata", bus.DRdata, 32'h0);
    reset = 1;
    step();

    // 1: single fetch, immediate ack
    bus.IReq = 1; bus.IAddr = 32'h40; bus.MemAck = 1; bus.MemRdata = 32'hE3A00001;
    step();
    check("t1_memreq", bus.MemReq, 1);
    check("t1_memwe", bus.MemWe, 0);
    check("t1_memaddr", bus.MemAddr, 32'h40);
    check("t1_iready_early", bus.IReady, 0);
    bus.IReq = 0;
    step();
    check("t1_iready", bus.IReady, 1);
    check("t1_irdata", bus.IRdata, 32'hE3A00001);
    check("t1_ierr", bus.IErr, 0);
    check("t1_memreq_drop", bus.MemReq, 0);
    check("t1_dready", bus.DReady, 0);
    bus.MemAck = 0;
    step();
    check("t1_iready_pulse", bus.IReady, 0);

    // 2: I and D together, D write wins first
    bus.IReq = 1; bus.IAddr = 32'h44;
    bus.DReq = 1; bus.DWe = 1; bus.DAddr = 32'h100; bus.DWdata = 32'hDEADBEEF;
    step();
    check("t2_memreq", bus.MemReq, 1);
    check("t2_memwe", bus.MemWe, 1);
    check("t2_memaddr", bus.MemAddr, 32'h100);
    check("t2_memwdata", bus.MemWdata, 32'hDEADBEEF);
    bus.DReq = 0; bus.MemAck = 1; bus.MemRdata = 32'h12345678;
    step();
    check("t2_dready", bus.DReady, 1);
    check("t2_drdata_write", bus.DRdata, 32'h0);
    check("t2_no_iready", bus.IReady, 0);
    check("t2_memreq_drop", bus.MemReq, 0);
    bus.MemAck = 0;
    step();
    check("t2_dready_pulse", bus.DReady, 0);
    check("t2_i_memreq", bus.MemReq, 1);
    check("t2_i_memwe", bus.MemWe, 0);
    check("t2_i_memaddr", bus.MemAddr, 32'h44);
    bus.IReq = 0; bus.MemAck = 1; bus.MemRdata = 32'hAAAA5555;
    step();
    check("t2_iready", bus.IReady, 1);
    check("t2_irdata", bus.IRdata, 32'hAAAA5555);
    check("t2_no_dready", bus.DReady, 0);
    bus.MemAck = 0;
    step();

    // 3: D held with I waiting: 4 D grants then 1 I grant, repeated
    bus.DReq = 1; bus.DWe = 0; bus.DAddr = 32'h200;
    bus.IReq = 1; bus.IAddr = 32'h300;
    bus.MemAck = 1; bus.MemRdata = 32'h11111111;
    for (int i = 0; i < 10; i++) begin
      logic is_i;
      is_i = ((i % 5) == 4);
      step();
      check($sformatf("t3_grant%0d_addr", i), bus.MemAddr, is_i ? 32'h300 : 32'h200);
      check($sformatf("t3_grant%0d_req", i), bus.MemReq, 1);
      step();
      check($sformatf("t3_done%0d_iready", i), bus.IReady, {31'd0, is_i});
      check($sformatf("t3_done%0d_dready", i), bus.DReady, {31'd0, ~is_i});
    end
    bus.DReq = 0; bus.IReq = 0; bus.MemAck = 0;
    step();

    // 4: timeout on a D read with no ack
    bus.DReq = 1; bus.DWe = 0; bus.DAddr = 32'h80;
    step();
    check("t4_memreq", bus.MemReq, 1);
    bus.DReq = 0;
    for (int i = 0; i < 7; i++) step();
    check("t4_memreq_held", bus.MemReq, 1);
    check("t4_no_dready_yet", bus.DReady, 0);
    step();
    check("t4_memreq_drop", bus.MemReq, 0);
    check("t4_dready", bus.DReady, 1);
    check("t4_derr", bus.DErr, 1);
    check("t4_drdata", bus.DRdata, 32'h0);
    step();
    check("t4_pulse", {bus.DReady, bus.DErr}, 0);

    // 5: ack on the expiry edge completes normally
    bus.DReq = 1; bus.DWe = 0; bus.DAddr = 32'h84;
    step();
    bus.DReq = 0;
    for (int i = 0; i < 7; i++) step();
    check("t5_memreq_held", bus.MemReq, 1);
    bus.MemAck = 1; bus.MemRdata = 32'hCAFEF00D;
    step();
    check("t5_dready", bus.DReady, 1);
    check("t5_derr", bus.DErr, 0);
    check("t5_drdata", bus.DRdata, 32'hCAFEF00D);
    bus.MemAck = 0;
    step();

    // 6: reset mid BUSY_D
    bus.DReq = 1; bus.DWe = 1; bus.DAddr = 32'h180; bus.DWdata = 32'h55AA55AA;
    step();
    check("t6_memreq", bus.MemReq, 1);
    bus.DReq = 0;
    #2 reset = 0;
    #1;
    check("t6_rst_flags", flags(), 32'h0);
    check("t6_rst_addr", bus.MemAddr, 32'h0);
    check("t6_rst_wdata", bus.MemWdata, 32'h0);
    check("t6_rst_drdata", bus.DRdata, 32'h0);
    bus.MemAck = 1;
    step();
    reset = 1;
    step();
    check("t6_no_dready", bus.DReady, 0);
    check("t6_idle_memreq", bus.MemReq, 0);
    bus.IReq = 1; bus.IAddr = 32'h500; bus.MemRdata = 32'h0BADC0DE;
    step();
    check("t6_i_memreq", bus.MemReq, 1);
    check("t6_i_memaddr", bus.MemAddr, 32'h500);
    bus.IReq = 0;
    step();
    check("t6_iready", bus.IReady, 1);
    check("t6_irdata", bus.IRdata, 32'h0BADC0DE);
    check("t6_ierr", bus.IErr, 0);
    bus.MemAck = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
